byte_unstriping: RTL and testbench

//  Receive-side counterpart of the byte striping stage: merges the two 32-bit lanes
//  (lane_0/valid_0, lane_1/valid_1) back into one ordered word stream at clk_2f.

---
 rtl/byte_unstriping_pkg.sv | 21 ++
 rtl/byte_unstriping_fifo.sv | 55 +++++
 rtl/byte_unstriping.sv | 115 +++++++++++
 tb/tb_byte_unstriping.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/byte_unstriping_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : byte_unstriping_pkg                                          |
// | Description : Shared defaults and lane-select encoding for the two-lane    |
// |               byte unstriping block.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package byte_unstriping_pkg;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 2;

  // Which lane FIFO supplies the next word of the merged stream.
  typedef enum logic {
    LANE_0 = 1'b0,
    LANE_1 = 1'b1
  } lane_sel_t;

endpackage
`default_nettype wire

// File: rtl/byte_unstriping_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : unstripe_fifo                                                |
// | Description : Per-lane synchronous FIFO. Pointers carry one extra wrap bit |
// |               so full and empty are distinguished without a counter.       |
// |               The head word is presented combinationally on dout.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module unstripe_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = (1 << ADDR_W)
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk_2f) begin
    if (push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
    end
  end

  // Read/write pointers wrap modulo 2*DEPTH via the extra MSB.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Equal pointers mean empty; same slot on opposite laps means full.
  always_comb begin
    empty = (r_wr_ptr == r_rd_ptr);
    full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
            (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    dout  = r_mem[r_rd_ptr[ADDR_W-1:0]];
  end

endmodule
`default_nettype wire

// File: rtl/byte_unstriping.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : byte_unstriping                                              |
// | Description : Merges two 32-bit lanes back into one ordered word stream.   |
// |               Each lane is buffered in its own FIFO; words are popped      |
// |               alternately lane 0, lane 1, ... and the block stalls on the  |
// |               expected lane rather than let the other lane overtake.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module byte_unstriping
  import byte_unstriping_pkg::*;
#(
  parameter int DATA_W     = byte_unstriping_pkg::DATA_W,
  parameter int FIFO_DEPTH = byte_unstriping_pkg::FIFO_DEPTH,
  parameter int ADDR_W     = byte_unstriping_pkg::ADDR_W
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] lane_0,
  input  logic              valid_1,
  input  logic [DATA_W-1:0] lane_1,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              overflow_0,
  output logic              overflow_1
);

  lane_sel_t         r_sel;
  logic              r_valid_out;
  logic [DATA_W-1:0] r_data_out;
  logic              r_overflow_0;
  logic              r_overflow_1;

  logic              w_push_0, w_push_1;
  logic              w_pop_0,  w_pop_1;
  logic              w_empty_0, w_empty_1;
  logic              w_full_0,  w_full_1;
  logic [DATA_W-1:0] w_dout_0,  w_dout_1;

  // Pop only the lane we are waiting on; a full FIFO being popped can still take a push.
  always_comb begin
    w_pop_0  = (r_sel == LANE_0) && !w_empty_0;
    w_pop_1  = (r_sel == LANE_1) && !w_empty_1;
    w_push_0 = valid_0 && (!w_full_0 || w_pop_0);
    w_push_1 = valid_1 && (!w_full_1 || w_pop_1);
  end

  unstripe_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo_0 (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .push    (w_push_0),
    .din     (lane_0),
    .pop     (w_pop_0),
    .dout    (w_dout_0),
    .empty   (w_empty_0),
    .full    (w_full_0)
  );

  unstripe_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo_1 (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .push    (w_push_1),
    .din     (lane_1),
    .pop     (w_pop_1),
    .dout    (w_dout_1),
    .empty   (w_empty_1),
    .full    (w_full_1)
  );

  // Output register and lane selector: emit the head of the selected lane, else hold.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_sel       <= LANE_0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else if (w_pop_0) begin
      r_sel       <= LANE_1;
      r_valid_out <= 1'b1;
      r_data_out  <= w_dout_0;
    end else if (w_pop_1) begin
      r_sel       <= LANE_0;
      r_valid_out <= 1'b1;
      r_data_out  <= w_dout_1;
    end else begin
      r_valid_out <= 1'b0;
    end
  end

  // Sticky overflow: a valid word arrived while its FIFO was full and not draining.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_overflow_0 <= 1'b0;
      r_overflow_1 <= 1'b0;
    end else begin
      if (valid_0 && w_full_0 && !w_pop_0) r_overflow_0 <= 1'b1;
      if (valid_1 && w_full_1 && !w_pop_1) r_overflow_1 <= 1'b1;
    end
  end

  assign valid_out  = r_valid_out;
  assign data_out   = r_data_out;
  assign overflow_0 = r_overflow_0;
  assign overflow_1 = r_overflow_1;

endmodule
`default_nettype wire

// File: tb/tb_byte_unstriping.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_byte_unstriping                                           |
// | Description : Self-checking bench for byte_unstriping. A queue-based       |
// |               model of the stream tracks the expected merged words.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_byte_unstriping;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk_2f = 1'b0;
  logic          reset_L = 1'b0;
  logic          valid_0 = 1'b0;
  logic [DW-1:0] lane_0  = '0;
  logic          valid_1 = 1'b0;
  logic [DW-1:0] lane_1  = '0;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          overflow_0;
  logic          overflow_1;

  int errors = 0;
  int checks = 0;

  // Reference model state: the queued words of each lane and the next lane owed.
  logic [DW-1:0] m_q0[$];
  logic [DW-1:0] m_q1[$];
  int            m_next_lane;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ovf0;
  logic          m_ovf1;

  byte_unstriping dut (
    .clk_2f     (clk_2f),
    .reset_L    (reset_L),
    .valid_0    (valid_0),
    .lane_0     (lane_0),
    .valid_1    (valid_1),
    .lane_1     (lane_1),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .overflow_0 (overflow_0),
    .overflow_1 (overflow_1)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid_out"},  {31'd0, valid_out},  {31'd0, m_valid});
    check({tag, ".data_out"},   data_out,            m_data);
    check({tag, ".overflow_0"}, {31'd0, overflow_0}, {31'd0, m_ovf0});
    check({tag, ".overflow_1"}, {31'd0, overflow_1}, {31'd0, m_ovf1});
  endtask

  task automatic model_reset();
    m_q0.delete();
    m_q1.delete();
    m_next_lane = 0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_ovf0      = 1'b0;
    m_ovf1      = 1'b0;
  endtask

  // Advance the model one clock: the owed lane emits its oldest word if it has one,
  // then each valid lane enqueues if room remains after that emission.
  task automatic model_edge(input logic v0, input logic [DW-1:0] d0,
                            input logic v1, input logic [DW-1:0] d1);
    m_valid = 1'b0;
    if (m_next_lane == 0 && m_q0.size() > 0) begin
      m_data = m_q0.pop_front(); m_valid = 1'b1; m_next_lane = 1;
    end else if (m_next_lane == 1 && m_q1.size() > 0) begin
      m_data = m_q1.pop_front(); m_valid = 1'b1; m_next_lane = 0;
    end
    if (v0) begin
      if (m_q0.size() < DEPTH) m_q0.push_back(d0);
      else                     m_ovf0 = 1'b1;
    end
    if (v1) begin
      if (m_q1.size() < DEPTH) m_q1.push_back(d1);
      else                     m_ovf1 = 1'b1;
    end
  endtask

  // One cycle: drive at the falling edge, update the model at the rising edge, check after.
  task automatic step(input string tag, input logic v0, input logic [DW-1:0] d0,
                      input logic v1, input logic [DW-1:0] d1);
    @(negedge clk_2f);
    valid_0 = v0; lane_0 = d0; valid_1 = v1; lane_1 = d1;
    @(posedge clk_2f);
    model_edge(v0, d0, v1, d1);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, $urandom, 1'b0, $urandom);
  endtask

  task automatic random_traffic(input string tag, input int n);
    for (int i = 0; i < n; i++)
      step(tag, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom);
  endtask

  // Asynchronous reset asserted between edges, held three cycles, released after a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk_2f);
    #2 reset_L = 1'b0;
    model_reset();
    #1 check_all({tag, ".async"});
    for (int i = 0; i < 3; i++) begin
      valid_0 = 1'($urandom_range(0, 1)); lane_0 = $urandom;
      valid_1 = 1'($urandom_range(0, 1)); lane_1 = $urandom;
      @(posedge clk_2f);
      #1 check_all({tag, ".held"});
    end
    @(negedge clk_2f);
    valid_0 = 1'b0; valid_1 = 1'b0;
    reset_L = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 check_all("por");
    repeat (2) @(posedge clk_2f);
    @(negedge clk_2f) reset_L = 1'b1;

    // 1. random traffic, reset mid-stream, then confirm lane 0 is owed first
    random_traffic("rand_a", 60);
    do_reset("rst_mid");
    step("after_rst", 1'b0, 32'h0, 1'b1, 32'h5555_AAAA);
    step("after_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    step("after_rst", 1'b1, 32'h1234_5678, 1'b0, 32'h0);
    idle("after_rst", 3);

    // 2. alternating lanes
    step("alt", 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h8888_8888);
    step("alt", 1'b1, 32'hDDDD_DDDD, 1'b1, 32'h7777_7777);
    idle("alt", 4);

    // 3. lane 0 leads lane 1 by three cycles
    step("skew", 1'b1, 32'h1111_1111, 1'b0, 32'h0);
    step("skew", 1'b1, 32'h4444_4444, 1'b0, 32'h0);
    step("skew", 1'b0, 32'h0, 1'b0, 32'h0);
    step("skew", 1'b0, 32'h0, 1'b1, 32'hAAAA_AAAA);
    step("skew", 1'b0, 32'h0, 1'b1, 32'h3333_3333);
    idle("skew", 4);

    // 4. an invalid lane-0 word must be ignored
    step("inval", 1'b0, 32'h090D_70F3, 1'b0, 32'h0);
    step("inval", 1'b1, 32'hC0DE_0001, 1'b1, 32'hC0DE_0002);
    idle("inval", 4);

    // 5. lane 1 stalled, five lane-0 words into a four-deep FIFO
    do_reset("rst5");
    step("ovf", 1'b1, 32'hA000_0000, 1'b0, 32'h0);
    for (int i = 1; i <= 5; i++) step("ovf", 1'b1, 32'hB000_0000 + i, 1'b0, 32'h0);
    idle("ovf", 2);
    for (int i = 0; i < 6; i++) step("ovf_drain", 1'b0, 32'h0, 1'b1, 32'hE000_0000 + i);
    idle("ovf_drain", 6);

    // 6. lane 0 full and popped in the same cycle as a new lane-0 word
    do_reset("rst6");
    step("fullpop", 1'b1, 32'h6000_0000, 1'b0, 32'h0);
    for (int i = 1; i <= 4; i++) step("fullpop", 1'b1, 32'h6000_0000 + i, 1'b0, 32'h0);
    step("fullpop", 1'b0, 32'h0, 1'b1, 32'h6100_0000);
    step("fullpop", 1'b0, 32'h0, 1'b0, 32'h0);
    step("fullpop", 1'b1, 32'h6000_0005, 1'b0, 32'h0);
    for (int i = 1; i <= 5; i++) step("fullpop_drain", 1'b0, 32'h0, 1'b1, 32'h6100_0000 + i);
    idle("fullpop_drain", 6);

    // closing random run
    random_traffic("rand_b", 200);
    idle("rand_b", 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
